// File: rtl/qspi_flash_responder.sv
// SPI NOR flash responder (memory side of the qspi_mem_controller link).
// Answers the single-bit extended-SPI command set from a small internal byte
// array.  SPI mode 0, MSB first, DQ0 in / DQ1 out.  All logic runs on clk,
// which must be at least 4x the SPI clock.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high
//   spi_c     SPI clock C from the master
//   spi_s_n   chip select S, active low
//   spi_d     DQ0, master-to-responder data
//   spi_q     DQ1, responder-to-master data (changes only on C fall)
//   spi_q_oe  output enable for DQ1
//   wip       write/erase in progress
//   wel       write enable latch
//
// Protocol FSM:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_CMD    | collecting the command byte
//   ST_ADDR   | collecting the 3 address bytes (READ, PP, SE)
//   ST_DIN    | PP data bytes, each ANDed into the array
//   ST_DOUT   | shifting response bytes out on DQ1
//   ST_IGNORE | swallow the rest of the frame
//
// Busy engine:
//   state     | meaning
//   ----------+----------------------------------------------------------
//   B_IDLE    | no program/erase in progress
//   B_PROG    | page program timer running
//   B_SWEEP   | writing 0xFF one byte per clk over the erase region
//   B_WAIT    | erase timer running after the sweep
module qspi_flash_responder #(
    parameter int          MEM_AW       = 10,
    parameter int          SE_AW        = 8,
    parameter logic [23:0] JEDEC_ID     = 24'h20BA18,
    parameter int          PROG_CYCLES  = 64,
    parameter int          ERASE_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_c,
    input  logic spi_s_n,
    input  logic spi_d,
    output logic spi_q,
    output logic spi_q_oe,
    output logic wip,
    output logic wel
);

    localparam logic [7:0] CMD_RDID = 8'h9F;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_RFSR = 8'h70;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'hD8;
    localparam logic [7:0] CMD_BE   = 8'hC7;

    localparam int TMR_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [MEM_AW-1:0] SE_MASK = MEM_AW'((1 << SE_AW) - 1);

    typedef enum logic [2:0] {ST_CMD, ST_ADDR, ST_DIN, ST_DOUT, ST_IGNORE} state_t;
    typedef enum logic [1:0] {B_IDLE, B_PROG, B_SWEEP, B_WAIT} busy_t;
    typedef enum logic [2:0] {ACT_NONE, ACT_WREN, ACT_PP, ACT_SE, ACT_BE} act_t;

    logic [7:0] mem [2**MEM_AW];

    logic c_meta, c_sync, c_prev;
    logic s_meta, s_sync, s_prev;
    logic d_meta, d_sync;

    state_t            state, state_nxt;
    busy_t             busy, busy_nxt;
    act_t              act_q, act_dec;
    logic [2:0]        bit_cnt;
    logic [2:0]        byte_cnt;
    logic [1:0]        addr_cnt;
    logic [1:0]        resp_idx;
    logic [6:0]        shift;
    logic [7:0]        cmd_q;
    logic [7:0]        out_sr;
    logic [MEM_AW-1:0] addr_q;
    logic              pp_data;

    logic [TMR_W-1:0]  timer;
    logic [MEM_AW-1:0] sweep_addr;
    logic [MEM_AW-1:0] sweep_left;

    logic              c_rise, c_fall, s_rise, byte_done;
    logic [7:0]        rx_byte;
    logic [MEM_AW-1:0] addr_shift;
    logic [7:0]        cur_cmd;
    logic [MEM_AW-1:0] rd_ptr;
    logic              load_out;
    logic [7:0]        load_val;
    logic              commit_wren, commit_pp, commit_se, commit_be;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [7:0]        mem_wdata;

    // C edges are ignored while S is high, so S wins over a coincident C edge.
    assign c_rise     = c_sync & ~c_prev & ~s_sync;
    assign c_fall     = ~c_sync & c_prev & ~s_sync;
    assign s_rise     = s_sync & ~s_prev;
    assign byte_done  = c_rise & (bit_cnt == 3'd7);
    assign rx_byte    = {shift, d_sync};
    assign addr_shift = {addr_q[MEM_AW-2:0], d_sync};

    assign wip      = (busy != B_IDLE);
    assign spi_q_oe = (state == ST_DOUT) & ~s_sync;

    // Commits need a whole number of bytes at S rise.
    assign commit_wren = s_rise & (bit_cnt == 3'd0) & (act_q == ACT_WREN);
    assign commit_pp   = s_rise & (bit_cnt == 3'd0) & (act_q == ACT_PP) & pp_data;
    assign commit_se   = s_rise & (bit_cnt == 3'd0) & (act_q == ACT_SE) & (byte_cnt == 3'd4);
    assign commit_be   = s_rise & (bit_cnt == 3'd0) & (act_q == ACT_BE) & (byte_cnt == 3'd1);

    always_comb begin
        state_nxt = state;
        act_dec   = ACT_NONE;
        load_out  = 1'b0;
        load_val  = 8'h00;
        cur_cmd   = (state == ST_CMD) ? rx_byte : cmd_q;
        rd_ptr    = (state == ST_ADDR) ? addr_shift : addr_q;
        if (byte_done) begin
            case (state)
                ST_CMD: begin
                    state_nxt = ST_IGNORE;
                    case (rx_byte)
                        CMD_RDSR, CMD_RFSR: begin
                            state_nxt = ST_DOUT;
                            load_out  = 1'b1;
                        end
                        CMD_RDID: if (!wip) begin
                            state_nxt = ST_DOUT;
                            load_out  = 1'b1;
                        end
                        CMD_READ: if (!wip) state_nxt = ST_ADDR;
                        CMD_PP: if (!wip && wel) begin
                            state_nxt = ST_ADDR;
                            act_dec   = ACT_PP;
                        end
                        CMD_SE: if (!wip && wel) begin
                            state_nxt = ST_ADDR;
                            act_dec   = ACT_SE;
                        end
                        CMD_BE:   if (!wip && wel) act_dec = ACT_BE;
                        CMD_WREN: if (!wip) act_dec = ACT_WREN;
                        default: ;
                    endcase
                end
                ST_ADDR: if (addr_cnt == 2'd2) begin
                    case (cmd_q)
                        CMD_READ: begin
                            state_nxt = ST_DOUT;
                            load_out  = 1'b1;
                        end
                        CMD_PP:  state_nxt = ST_DIN;
                        default: state_nxt = ST_IGNORE;
                    endcase
                end
                ST_DOUT: load_out = 1'b1;
                default: ;
            endcase
        end
        if (load_out) begin
            case (cur_cmd)
                CMD_RDID: begin
                    case (resp_idx)
                        2'd0:    load_val = JEDEC_ID[23:16];
                        2'd1:    load_val = JEDEC_ID[15:8];
                        2'd2:    load_val = JEDEC_ID[7:0];
                        default: load_val = 8'h00;
                    endcase
                end
                CMD_RDSR: load_val = {6'b0, wel, wip};
                CMD_RFSR: load_val = {~wip, 7'b0};
                CMD_READ: load_val = mem[rd_ptr];
                default:  load_val = 8'h00;
            endcase
        end
        if (s_sync) state_nxt = ST_CMD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta   <= 1'b0;
            c_sync   <= 1'b0;
            c_prev   <= 1'b0;
            s_meta   <= 1'b1;
            s_sync   <= 1'b1;
            s_prev   <= 1'b1;
            d_meta   <= 1'b0;
            d_sync   <= 1'b0;
            state    <= ST_CMD;
            bit_cnt  <= 3'd0;
            byte_cnt <= 3'd0;
            addr_cnt <= 2'd0;
            resp_idx <= 2'd0;
            shift    <= 7'd0;
            cmd_q    <= 8'h00;
            out_sr   <= 8'h00;
            addr_q   <= '0;
            act_q    <= ACT_NONE;
            pp_data  <= 1'b0;
            spi_q    <= 1'b0;
        end else begin
            c_meta <= spi_c;
            c_sync <= c_meta;
            c_prev <= c_sync;
            s_meta <= spi_s_n;
            s_sync <= s_meta;
            s_prev <= s_sync;
            d_meta <= spi_d;
            d_sync <= d_meta;
            state  <= state_nxt;

            if (s_sync) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 3'd0;
                addr_cnt <= 2'd0;
                resp_idx <= 2'd0;
                act_q    <= ACT_NONE;
                pp_data  <= 1'b0;
            end else if (c_rise) begin
                shift   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (state == ST_ADDR) addr_q <= addr_shift;
                if (byte_done) begin
                    if (byte_cnt != 3'd7) byte_cnt <= byte_cnt + 3'd1;
                    if (state == ST_CMD) begin
                        cmd_q <= rx_byte;
                        act_q <= act_dec;
                    end
                    if (state == ST_ADDR) addr_cnt <= addr_cnt + 2'd1;
                    if (state == ST_DIN) begin
                        pp_data <= 1'b1;
                        // Page wrap: only the low byte of the address advances.
                        addr_q  <= {addr_q[MEM_AW-1:8], addr_q[7:0] + 8'd1};
                    end
                end
            end

            if (load_out) begin
                out_sr <= load_val;
                if (cur_cmd == CMD_RDID && resp_idx != 2'd3) resp_idx <= resp_idx + 2'd1;
                if (cur_cmd == CMD_READ) addr_q <= rd_ptr + MEM_AW'(1);
            end

            if (c_fall && state == ST_DOUT) begin
                spi_q  <= out_sr[7];
                out_sr <= {out_sr[6:0], 1'b0};
            end
        end
    end

    always_comb begin
        busy_nxt = busy;
        case (busy)
            B_IDLE: begin
                if (commit_pp)                   busy_nxt = B_PROG;
                else if (commit_se || commit_be) busy_nxt = B_SWEEP;
            end
            B_SWEEP: if (sweep_left == '0) busy_nxt = B_WAIT;
            B_PROG, B_WAIT: if (timer == '0) busy_nxt = B_IDLE;
            default: busy_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= B_IDLE;
            timer      <= '0;
            sweep_addr <= '0;
            sweep_left <= '0;
            wel        <= 1'b0;
        end else begin
            busy <= busy_nxt;
            case (busy)
                B_IDLE: begin
                    if (commit_wren) wel <= 1'b1;
                    if (commit_pp) timer <= TMR_W'(PROG_CYCLES - 1);
                    if (commit_se) begin
                        sweep_addr <= addr_q & ~SE_MASK;
                        sweep_left <= SE_MASK;
                    end
                    if (commit_be) begin
                        sweep_addr <= '0;
                        sweep_left <= '1;
                    end
                end
                B_SWEEP: begin
                    sweep_addr <= sweep_addr + MEM_AW'(1);
                    if (sweep_left == '0) timer <= TMR_W'(ERASE_CYCLES - 1);
                    else                  sweep_left <= sweep_left - MEM_AW'(1);
                end
                B_PROG, B_WAIT: begin
                    if (timer == '0) wel <= 1'b0;
                    else             timer <= timer - TMR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sweep and PP data can never coincide: PP is refused while busy.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = mem[addr_q] & rx_byte;
        if (!reset && busy == B_SWEEP) begin
            mem_we    = 1'b1;
            mem_waddr = sweep_addr;
            mem_wdata = 8'hFF;
        end else if (!reset && byte_done && state == ST_DIN) begin
            mem_we = 1'b1;
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: a table of SPI frames with
// hand-computed response bytes and status, plus polling and reset sequences.
module tb_qspi_flash_responder;

    localparam int HALF = 40;
    localparam int NV   = 22;

    logic clk = 1'b0;
    logic reset;
    logic spi_c, spi_s_n, spi_d;
    logic spi_q, spi_q_oe, wip, wel;

    int n_checks = 0;
    int n_errors = 0;

    qspi_flash_responder dut (
        .clk      (clk),
        .reset    (reset),
        .spi_c    (spi_c),
        .spi_s_n  (spi_s_n),
        .spi_d    (spi_d),
        .spi_q    (spi_q),
        .spi_q_oe (spi_q_oe),
        .wip      (wip),
        .wel      (wel)
    );

    always #5 clk = ~clk;

    // Byte i of tx/exp lives in bits [63-8*i -: 8]; mask bit i marks a
    // response byte that must be checked and must have spi_q_oe high.
    typedef struct packed {
        logic [63:0] tx;
        int          nbytes;
        int          cut;
        logic [63:0] exp;
        logic [7:0]  mask;
        logic        exp_wip;
        logic        exp_wel;
        logic        wait_idle;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_frame(input logic [63:0] tx, input int nbytes, input int cut,
                            output logic [63:0] rx, output logic [7:0] oe_all,
                            output logic [7:0] oe_any);
        int nb;
        rx     = '0;
        oe_all = '0;
        oe_any = '0;
        spi_s_n = 1'b0;
        for (int i = 0; i < nbytes + ((cut > 0) ? 1 : 0); i++) begin
            nb = (i < nbytes) ? 8 : cut;
            oe_all[i] = 1'b1;
            for (int b = 0; b < nb; b++) begin
                spi_d = tx[63 - 8*i - b];
                #(HALF);
                rx[63 - 8*i - b] = spi_q;
                if (spi_q_oe) oe_any[i] = 1'b1;
                else          oe_all[i] = 1'b0;
                spi_c = 1'b1;
                #(HALF);
                spi_c = 1'b0;
            end
        end
        #(HALF);
        spi_s_n = 1'b1;
        spi_d   = 1'b0;
        #(2*HALF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rx;
        logic [7:0]  oa, ob;
        logic        done;

        vecs[0]  = '{64'h9F00_0000_0000_0000, 5, 0, 64'h0020_BA18_0000_0000, 8'h1E, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{64'h0600_0000_0000_0000, 1, 0, 64'h0,                   8'h00, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{64'h0500_0000_0000_0000, 2, 0, 64'h0002_0000_0000_0000, 8'h02, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{64'h0500_0000_0000_0000, 4, 0, 64'h0002_0202_0000_0000, 8'h0E, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{64'h7000_0000_0000_0000, 2, 0, 64'h0080_0000_0000_0000, 8'h02, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{64'hC700_0000_0000_0000, 1, 0, 64'h0,                   8'h00, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{64'h0500_0000_0000_0000, 2, 0, 64'h0003_0000_0000_0000, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{64'h0200_0030_0000_0000, 5, 0, 64'h0,                   8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{64'hD800_0000_0000_0000, 4, 0, 64'h0,                   8'h00, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{64'h7000_0000_0000_0000, 2, 0, 64'h0000_0000_0000_0000, 8'h02, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{64'h0300_0010_0000_0000, 8, 0, 64'h0000_0000_FFFF_FFFF, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{64'h0300_0030_0000_0000, 5, 0, 64'h0000_0000_FF00_0000, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{64'h0600_0000_0000_0000, 1, 0, 64'h0,                   8'h00, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{64'h0200_00FE_A1B2_C300, 7, 0, 64'h0,                   8'h00, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{64'h0300_00FE_0000_0000, 7, 0, 64'h0000_0000_A1B2_FF00, 8'h70, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{64'h0300_0000_0000_0000, 5, 0, 64'h0000_0000_C300_0000, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{64'h0200_0010_5500_0000, 5, 0, 64'h0,                   8'h00, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{64'h0300_0010_0000_0000, 5, 0, 64'h0000_0000_FF00_0000, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{64'h0600_0000_0000_0000, 1, 0, 64'h0,                   8'h00, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{64'h0200_0040_0000_0000, 4, 5, 64'h0,                   8'h00, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{64'h0300_0040_0000_0000, 5, 0, 64'h0000_0000_FF00_0000, 8'h10, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{64'h0500_0000_0000_0000, 2, 0, 64'h0002_0000_0000_0000, 8'h02, 1'b0, 1'b1, 1'b0};

        spi_c   = 1'b0;
        spi_s_n = 1'b1;
        spi_d   = 1'b0;
        reset   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset spi_q",    {63'b0, spi_q},    64'h0);
        check("reset spi_q_oe", {63'b0, spi_q_oe}, 64'h0);
        check("reset wip",      {63'b0, wip},      64'h0);
        check("reset wel",      {63'b0, wel},      64'h0);
        reset = 1'b0;
        #(2*HALF);

        for (int v = 0; v < NV; v++) begin
            do_frame(vecs[v].tx, vecs[v].nbytes, vecs[v].cut, rx, oa, ob);
            for (int i = 0; i < 8; i++) begin
                if (vecs[v].mask[i])
                    check($sformatf("v%0d byte%0d", v, i),
                          {56'b0, rx[63 - 8*i -: 8]}, {56'b0, vecs[v].exp[63 - 8*i -: 8]});
            end
            check($sformatf("v%0d oe_all", v), {56'b0, oa}, {56'b0, vecs[v].mask});
            check($sformatf("v%0d oe_any", v), {56'b0, ob}, {56'b0, vecs[v].mask});
            check($sformatf("v%0d oe_idle", v), {63'b0, spi_q_oe}, 64'h0);
            check($sformatf("v%0d wip", v), {63'b0, wip}, {63'b0, vecs[v].exp_wip});
            check($sformatf("v%0d wel", v), {63'b0, wel}, {63'b0, vecs[v].exp_wel});
            if (vecs[v].wait_idle) begin
                done = 1'b0;
                for (int p = 0; p < 60 && !done; p++) begin
                    do_frame(64'h7000_0000_0000_0000, 2, 0, rx, oa, ob);
                    if (rx[55:48] == 8'h80) done = 1'b1;
                end
                check($sformatf("v%0d poll ready", v), {63'b0, done}, 64'h1);
                check($sformatf("v%0d idle wip", v), {63'b0, wip}, 64'h0);
                check($sformatf("v%0d idle wel", v), {63'b0, wel}, 64'h0);
            end
        end

        // Reset in mid-frame returns the outputs and latches to idle.
        spi_s_n = 1'b0;
        spi_d   = 1'b1;
        #(HALF);
        spi_c = 1'b1;
        #(HALF);
        spi_c = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("mid reset wel", {63'b0, wel}, 64'h0);
        check("mid reset wip", {63'b0, wip}, 64'h0);
        check("mid reset oe",  {63'b0, spi_q_oe}, 64'h0);
        reset   = 1'b0;
        spi_s_n = 1'b1;
        spi_d   = 1'b0;
        #(2*HALF);
        do_frame(64'h9F00_0000_0000_0000, 2, 0, rx, oa, ob);
        check("post reset rdid", {56'b0, rx[55:48]}, 64'h20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
